uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parameterised oversampling UART receiver.
//
// Receives asynchronous serial frames (start, DATA_BITS data LSB-first,
// optional parity, one stop bit) on rxd. The line is sampled on
// r_enable ticks, OVS ticks per bit. Each bit is decided by majority of
// the low samples seen across the whole bit period.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-low reset
//   r_enable   in   oversample tick (OVS per bit period)
//   rxd        in   asynchronous serial line, idle high
//   rec_enable in   1 = new frames may start
//   rd_ack     in   one-cycle pulse, consumer has taken data
//   data       out  last received word (LSB = first bit on the line)
//   rda        out  received data available
//   frame_err  out  stop bit of the held word sampled low
//   parity_err out  parity mismatch on the held word
//   overrun    out  sticky, a word was overwritten before rd_ack
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r_enable,
  input  logic                 rxd,
  input  logic                 rec_enable,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam logic [5:0] OVS_CNT  = 6'(OVS);
  localparam logic [5:0] HALF_CNT = 6'(OVS / 2);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       PAR_EN   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  logic                   rxd_meta;
  logic                   rxd_sync;
  logic [1:0]             sync_fill;
  logic                   armed;
  logic [5:0]             tick_cnt;
  logic [5:0]             zero_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_err_pend;

  logic [5:0]             tick_next;
  logic [5:0]             zero_next;
  logic                   decide;
  logic                   bit_val;
  logic                   done;
  logic                   ack_ok;

  // Counter values including the current tick; a decision is due when
  // this tick is the OVS-th of the bit.
  always_comb begin
    tick_next = tick_cnt + 6'd1;
    zero_next = zero_cnt + {5'd0, ~rxd_sync};
    decide    = (tick_next == OVS_CNT);
    bit_val   = !(zero_next > HALF_CNT);
    done      = r_enable && (state == STOP) && decide;
    ack_ok    = rd_ack && rda;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      rxd_meta     <= 1'b1;
      rxd_sync     <= 1'b1;
      sync_fill    <= 2'b00;
      armed        <= 1'b0;
      tick_cnt     <= 6'd0;
      zero_cnt     <= 6'd0;
      bit_cnt      <= 4'd0;
      shift_reg    <= '0;
      par_err_pend <= 1'b0;
      data         <= '0;
      rda          <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;

      // The synchroniser holds its reset value for two edges after
      // release. Starts are only accepted once a genuine high line has
      // come through it, so a line already low at release is not
      // mistaken for a start edge.
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rxd_sync) begin
        armed <= 1'b1;
      end

      // Output word handshake.
      if (done) begin
        data       <= shift_reg;
        frame_err  <= ~bit_val;
        parity_err <= PAR_EN ? par_err_pend : 1'b0;
        rda        <= 1'b1;
        if (rda && !rd_ack) begin
          overrun <= 1'b1;
        end
      end else if (ack_ok) begin
        rda     <= 1'b0;
        overrun <= 1'b0;
      end

      if (r_enable) begin
        if (state == IDLE) begin
          // The detecting tick is already sample 1 of the start bit.
          if (!rxd_sync && rec_enable && armed) begin
            state    <= START;
            tick_cnt <= 6'd1;
            zero_cnt <= 6'd1;
          end
        end else if (decide) begin
          tick_cnt <= 6'd0;
          zero_cnt <= 6'd0;
          case (state)
            START: begin
              bit_cnt <= 4'd0;
              state   <= bit_val ? IDLE : DATA;
            end
            DATA: begin
              shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                state <= PAR_EN ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            PARITY: begin
              par_err_pend <= (^shift_reg) ^ bit_val ^ PAR_ODD;
              state        <= STOP;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end else begin
          tick_cnt <= tick_next;
          zero_cnt <= zero_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- directed bench for uart_rx_param.
// Instantiates a default 8N1 receiver and an 8E1 (even parity) receiver.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       r_enable;
  logic       rxd;
  logic       rxd_p;
  logic       rec_enable;
  logic       rd_ack;
  logic       rd_ack_p;
  logic       half_rate;
  logic [7:0] data;
  logic [7:0] data_p;
  logic       rda, frame_err, parity_err, overrun;
  logic       rda_p, frame_err_p, parity_err_p, overrun_p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_param dut (
    .clk(clk), .rst(rst), .r_enable(r_enable), .rxd(rxd),
    .rec_enable(rec_enable), .rd_ack(rd_ack), .data(data), .rda(rda),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst(rst), .r_enable(r_enable), .rxd(rxd_p),
    .rec_enable(rec_enable), .rd_ack(rd_ack_p), .data(data_p), .rda(rda_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (half_rate) r_enable = ~r_enable;
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends start, nbits bits of val LSB-first, then stop_bit, each bit held
  // cyc clocks. Returns 1ns after the posedge that ends the stop bit.
  task automatic send(input bit which, input logic [8:0] val, input int nbits,
                      input logic stop_bit, input int cyc, input int drop_at);
    logic b;
    @(posedge clk);
    #1;
    for (int i = 0; i < nbits + 2; i++) begin
      if (i == 0) b = 1'b0;
      else if (i == nbits + 1) b = stop_bit;
      else b = val[i-1];
      if (which) rxd_p = b;
      else rxd = b;
      if (i == drop_at) rec_enable = 1'b0;
      cycles(cyc);
    end
    rxd   = 1'b1;
    rxd_p = 1'b1;
  endtask

  task automatic ack(input bit which);
    @(posedge clk);
    #1;
    if (which) rd_ack_p = 1'b1;
    else rd_ack = 1'b1;
    @(posedge clk);
    #1;
    rd_ack   = 1'b0;
    rd_ack_p = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    rst        = 1'b0;
    rxd        = 1'b1;
    rxd_p      = 1'b1;
    r_enable   = 1'b1;
    rec_enable = 1'b1;
    rd_ack     = 1'b0;
    rd_ack_p   = 1'b0;
    half_rate  = 1'b0;

    // Reset state.
    wait_neg(4);
    check("reset_data", data, 8'h00);
    check("reset_rda", rda, 1'b0);
    check("reset_flags", {frame_err, parity_err, overrun}, 3'b000);
    check("reset_rda_p", rda_p, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(3);

    // 0xA5 8N1: rda rises the cycle after the 16th stop tick.
    send(0, 9'h0A5, 8, 1'b1, 16, -1);
    wait_neg(2);
    check("a5_rda_before_stop_decision", rda, 1'b0);
    wait_neg(1);
    check("a5_rda", rda, 1'b1);
    check("a5_data", data, 8'hA5);
    check("a5_flags", {frame_err, parity_err, overrun}, 3'b000);
    ack(0);
    check("a5_ack_rda", rda, 1'b0);

    // Glitch: 6 low ticks is a false start.
    @(posedge clk);
    #1;
    rxd = 1'b0;
    cycles(6);
    rxd = 1'b1;
    wait_neg(30);
    check("glitch_rda", rda, 1'b0);
    check("glitch_data", data, 8'hA5);

    // Stop bit low on 0x3C.
    send(0, 9'h03C, 8, 1'b0, 16, -1);
    wait_neg(4);
    check("3c_data", data, 8'h3C);
    check("3c_rda", rda, 1'b1);
    check("3c_frame_err", frame_err, 1'b1);
    ack(0);

    // Two frames without acknowledge -> overrun.
    send(0, 9'h011, 8, 1'b1, 16, -1);
    wait_neg(4);
    check("11_data", data, 8'h11);
    check("11_frame_err", frame_err, 1'b0);
    check("11_overrun", overrun, 1'b0);
    send(0, 9'h022, 8, 1'b1, 16, -1);
    wait_neg(4);
    check("22_data", data, 8'h22);
    check("22_overrun", overrun, 1'b1);
    check("22_rda", rda, 1'b1);
    ack(0);
    check("22_ack_rda", rda, 1'b0);
    check("22_ack_overrun", overrun, 1'b0);

    // rec_enable low: start bits ignored.
    rec_enable = 1'b0;
    send(0, 9'h055, 8, 1'b1, 16, -1);
    wait_neg(4);
    check("recdis_rda", rda, 1'b0);
    check("recdis_data", data, 8'h22);
    rec_enable = 1'b1;

    // Completion and rd_ack on the same edge: no overrun, rda stays.
    send(0, 9'h044, 8, 1'b1, 16, -1);
    wait_neg(4);
    check("44_data", data, 8'h44);
    send(0, 9'h033, 8, 1'b1, 16, -1);
    @(posedge clk);
    #1;
    rd_ack = 1'b1;
    @(posedge clk);
    #1;
    rd_ack = 1'b0;
    @(negedge clk);
    check("33_same_cycle_rda", rda, 1'b1);
    check("33_same_cycle_data", data, 8'h33);
    check("33_same_cycle_overrun", overrun, 1'b0);
    ack(0);

    // Even parity: 0x07 has odd weight, so parity bit 0 is wrong.
    send(1, 9'h007, 9, 1'b1, 16, -1);
    wait_neg(4);
    check("par0_data", data_p, 8'h07);
    check("par0_rda", rda_p, 1'b1);
    check("par0_parity_err", parity_err_p, 1'b1);
    check("par0_frame_err", frame_err_p, 1'b0);
    ack(1);
    send(1, 9'h107, 9, 1'b1, 16, -1);
    wait_neg(4);
    check("par1_parity_err", parity_err_p, 1'b0);
    check("par1_rda", rda_p, 1'b1);
    ack(1);

    // r_enable every other cycle, 32 clocks per bit.
    half_rate = 1'b1;
    send(0, 9'h096, 8, 1'b1, 32, -1);
    half_rate = 1'b0;
    r_enable  = 1'b1;
    wait_neg(8);
    check("half_rate_data", data, 8'h96);
    check("half_rate_rda", rda, 1'b1);

    // rec_enable dropped mid-frame: frame still completes (and overruns).
    send(0, 9'h0C3, 8, 1'b1, 16, 3);
    rec_enable = 1'b1;
    wait_neg(4);
    check("recdrop_data", data, 8'hC3);
    check("recdrop_overrun", overrun, 1'b1);

    // Reset during data bit 4 of 0x5A, line held low across release.
    v = 8'h5A;
    @(posedge clk);
    #1;
    rxd = 1'b0;
    cycles(16);
    for (int i = 0; i < 4; i++) begin
      rxd = v[i];
      cycles(16);
    end
    rxd = v[4];
    cycles(8);
    rst = 1'b0;
    rxd = 1'b0;
    cycles(3);
    @(negedge clk);
    check("midrst_data", data, 8'h00);
    check("midrst_rda", rda, 1'b0);
    check("midrst_flags", {frame_err, parity_err, overrun}, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(40);
    rxd = 1'b1;
    cycles(200);
    @(negedge clk);
    check("low_at_release_rda", rda, 1'b0);
    check("low_at_release_data", data, 8'h00);
    send(0, 9'h05A, 8, 1'b1, 16, -1);
    wait_neg(4);
    check("5a_data", data, 8'h5A);
    check("5a_rda", rda, 1'b1);
    check("5a_flags", {frame_err, parity_err, overrun}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
